// File: rtl/gap_pkg.sv
// gap_pkg: state encoding and default timing constants shared across the gap-state loop.
package gap_pkg;
    typedef enum logic [2:0] {IDLE, ON, OFF, WAIT, ADJ} state_t;
    localparam int PCT_FULL     = 100;
    localparam int D_CNT_W      = 16;
    localparam int D_TON        = 50;
    localparam int D_TOFF_DEF   = 100;
    localparam int D_TOFF_MIN   = 20;
    localparam int D_TOFF_MAX   = 1000;
    localparam int D_STEP       = 10;
    localparam int D_HI_PCT     = 30;
    localparam int D_LO_PCT     = 10;
    localparam int D_WIN_PULSES = 64;
    localparam int D_TMO        = 255;
endpackage

// File: rtl/gap_pulse_gen_toff_adapt.sv
// toff_adapt: saturating step of the off-time from the latched short percentage.
module toff_adapt import gap_pkg::*; #(
    parameter int CNT_W    = D_CNT_W,
    parameter int TOFF_MIN = D_TOFF_MIN,
    parameter int TOFF_MAX = D_TOFF_MAX,
    parameter int STEP     = D_STEP,
    parameter int HI_PCT   = D_HI_PCT,
    parameter int LO_PCT   = D_LO_PCT
) (
    input  logic [CNT_W-1:0] toff,
    input  logic [6:0]       pct,
    output logic [CNT_W-1:0] toff_nxt
);
    localparam logic [CNT_W:0] MIN_W  = (CNT_W+1)'(TOFF_MIN);
    localparam logic [CNT_W:0] MAX_W  = (CNT_W+1)'(TOFF_MAX);
    localparam logic [CNT_W:0] STEP_W = (CNT_W+1)'(STEP);
    localparam logic [6:0]     HI_P   = 7'(HI_PCT);
    localparam logic [6:0]     LO_P   = 7'(LO_PCT);
    logic [CNT_W:0] cur, sum, up, dn;
    always_comb begin
        cur = {1'b0, toff};
        sum = cur + STEP_W;
        up = sum > MAX_W ? MAX_W : sum;
        // compare before subtracting so the floor is reached without underflow
        dn = cur >= MIN_W + STEP_W ? cur - STEP_W : MIN_W;
        toff_nxt = pct > HI_P ? up[CNT_W-1:0] : pct < LO_P ? dn[CNT_W-1:0] : toff;
    end
endmodule

// File: rtl/gap_pulse_gen.sv
// gap_pulse_gen: discharge pulse train with per-window off-time adaptation.
// Optional sustained-short alarm enabled by defining GAP_SHORT_ALARM_EN.
module gap_pulse_gen import gap_pkg::*; #(
    parameter int CNT_W      = D_CNT_W,
    parameter int TON        = D_TON,
    parameter int TOFF_DEF   = D_TOFF_DEF,
    parameter int TOFF_MIN   = D_TOFF_MIN,
    parameter int TOFF_MAX   = D_TOFF_MAX,
    parameter int STEP       = D_STEP,
    parameter int HI_PCT     = D_HI_PCT,
    parameter int LO_PCT     = D_LO_PCT,
    parameter int WIN_PULSES = D_WIN_PULSES,
    parameter int TMO        = D_TMO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      ratio,
    input  logic             ratio_valid,
    output logic             pulse_out,
    output logic             win_done,
    output logic [CNT_W-1:0] toff_cur,
    output logic             timeout,
    output logic             alarm
);
    localparam int PW = $clog2(WIN_PULSES + 1);
    localparam int WW = $clog2(TMO + 1);
    localparam logic [CNT_W-1:0] TON_L    = CNT_W'(TON - 1);
    localparam logic [CNT_W-1:0] TOFF_RST = CNT_W'(TOFF_DEF);
    localparam logic [PW-1:0]    WIN_L    = PW'(WIN_PULSES - 1);
    localparam logic [WW-1:0]    TMO_L    = WW'(TMO - 1);
    state_t state, nxt;
    logic [CNT_W-1:0] timer, toff_nxt;
    logic [PW-1:0] pcnt;
    logic [WW-1:0] wcnt;
    logic [6:0] lat;
    logic ton_end, toff_end, got, alarm_hit;
    toff_adapt #(
        .CNT_W(CNT_W), .TOFF_MIN(TOFF_MIN), .TOFF_MAX(TOFF_MAX),
        .STEP(STEP), .HI_PCT(HI_PCT), .LO_PCT(LO_PCT)
    ) u_adapt (
        .toff(toff_cur),
        .pct(lat),
        .toff_nxt(toff_nxt)
    );
    always_comb begin
        ton_end = timer == TON_L;
        toff_end = timer == toff_cur - 1'b1;
        // a strobe coinciding with win_done belongs to the previous window
        got = ratio_valid && !win_done;
        nxt = state;
        case (state)
            IDLE:    nxt = ON;
            ON:      nxt = ton_end ? OFF : ON;
            OFF:     nxt = !toff_end ? OFF : pcnt == WIN_L ? WAIT : ON;
            WAIT:    nxt = got ? ADJ : wcnt == TMO_L ? ON : WAIT;
            ADJ:     nxt = alarm_hit ? IDLE : ON;
            default: nxt = IDLE;
        endcase
        if (!en || alarm) nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            pulse_out <= 1'b0;
            win_done <= 1'b0;
            timeout <= 1'b0;
            timer <= '0;
            pcnt <= '0;
            wcnt <= '0;
            lat <= '0;
            toff_cur <= TOFF_RST;
        end else begin
            state <= nxt;
            pulse_out <= state == ON && nxt != IDLE;
            win_done <= state == OFF && nxt == WAIT;
            timeout <= state == WAIT && nxt == ON;
            timer <= nxt != state ? '0 : timer + 1'b1;
            pcnt <= nxt == IDLE ? '0 : state == OFF && toff_end ? (nxt == WAIT ? '0 : pcnt + 1'b1) : pcnt;
            wcnt <= state == WAIT && nxt == WAIT ? wcnt + 1'b1 : '0;
            if (state == WAIT && got) lat <= ratio > 32'(PCT_FULL) ? 7'(PCT_FULL) : ratio[6:0];
            if (state == ADJ && en) toff_cur <= toff_nxt;
        end
`ifdef GAP_SHORT_ALARM_EN
    localparam logic [6:0]       HI_L  = 7'(HI_PCT);
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(TOFF_MAX);
    logic [1:0] run;
    logic hot;
    assign hot = state == ADJ && en && lat > HI_L && toff_cur == MAX_L;
    assign alarm_hit = hot && run == 2'd3;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            run <= '0;
            alarm <= 1'b0;
        end else if (!en) begin
            run <= '0;
            alarm <= 1'b0;
        end else begin
            alarm <= alarm || alarm_hit;
            if (state == ADJ) run <= hot ? run + 1'b1 : '0;
            else if (state == WAIT && nxt == ON) run <= '0;
        end
`else
    assign alarm = 1'b0;
    assign alarm_hit = 1'b0;
`endif
endmodule

// File: tb/tb_gap_pulse_gen.sv
// tb_gap_pulse_gen: directed scoreboard bench; stimulus queues expected events, a monitor pops them.
module tb_gap_pulse_gen;
    logic clk = 0, rst = 0, en = 0, ratio_valid = 0;
    logic [31:0] ratio = 0;
    logic pulse_out, win_done, timeout, alarm;
    logic [15:0] toff_cur;
    typedef struct packed {logic [1:0] k; logic [15:0] v;} ev_t;
    ev_t q[$];
    int cmp = 0, err = 0;
    bit m_prev = 0, m_seen = 0;
    int m_hi = 0, m_lo = 0;

    gap_pulse_gen #(
        .CNT_W(16), .TON(3), .TOFF_DEF(5), .TOFF_MIN(2), .TOFF_MAX(8), .STEP(2),
        .HI_PCT(30), .LO_PCT(10), .WIN_PULSES(2), .TMO(10)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ratio(ratio), .ratio_valid(ratio_valid),
        .pulse_out(pulse_out), .win_done(win_done), .toff_cur(toff_cur),
        .timeout(timeout), .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic string kname(input logic [1:0] k);
        if (k == 2'd0) return "on_len";
        if (k == 2'd1) return "gap_len";
        if (k == 2'd2) return "win_done_toff";
        return "timeout_toff";
    endfunction

    task automatic chk(input string nm, input int act, input int want);
        cmp++;
        if (act != want) begin
            err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    task automatic push(input logic [1:0] k, input int v);
        ev_t e;
        e.k = k;
        e.v = 16'(v);
        q.push_back(e);
    endtask

    task automatic window(input int t);
        push(0, 3); push(1, t); push(0, 3); push(2, t);
    endtask

    task automatic got(input logic [1:0] k, input int v);
        ev_t e;
        if (q.size() == 0) begin
            cmp++; err++;
            $display("FAIL unexpected_%s: got %0d, want no event", kname(k), v);
        end else begin
            e = q.pop_front();
            chk("event_kind", int'(k), int'(e.k));
            chk(kname(e.k), v, int'(e.v));
        end
    endtask

    // pulse lengths are reported on the falling edge, gaps on the next rising edge
    initial forever begin
        @(negedge clk);
        if (win_done) got(2, int'(toff_cur));
        if (timeout) got(3, int'(toff_cur));
        if (pulse_out && !m_prev && m_seen) got(1, m_lo);
        if (!pulse_out && m_prev) got(0, m_hi);
        if (pulse_out) m_hi = m_prev ? m_hi + 1 : 1;
        else m_lo = m_prev ? 1 : m_lo + 1;
        m_prev = pulse_out;
        m_seen = m_seen | pulse_out;
        if (!en || !rst) m_seen = 0;
    end

    task automatic wait_pulse(input logic v, input string nm);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (pulse_out == v) return;
        end
        cmp++; err++;
        $display("FAIL %s: got no pulse_out=%0d, want it within 300 cycles", nm, v);
    endtask

    task automatic wait_win(input string nm);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (win_done) return;
        end
        cmp++; err++;
        $display("FAIL %s: got no win_done, want it within 300 cycles", nm);
    endtask

    // first strobe lands with win_done and carries a decoy that must be ignored
    task automatic close(input int r, input int told, input int tnew, input bit more);
        wait_win("win_wait");
        if (more) begin
            push(1, told + 3);
            window(tnew);
        end
        ratio_valid = 1;
        ratio = r > 30 ? 0 : 90;
        @(posedge clk); #1;
        ratio = r;
        @(posedge clk); #1;
        ratio_valid = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pulse", pulse_out, 0);
        chk("rst_win", win_done, 0);
        chk("rst_tmo", timeout, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_toff", toff_cur, 5);
        rst = 1;
        @(posedge clk); #1;
        en = 1;
        window(5);
        @(posedge clk); #1;
        chk("lat_idle", pulse_out, 0);
        @(posedge clk); #1;
        chk("lat_on", pulse_out, 1);
        close(20, 5, 5, 1);
        close(50, 5, 7, 1);
        close(50, 7, 8, 1);
        close(50, 8, 8, 1);
        close(0, 8, 6, 1);
        close(0, 6, 4, 1);
        close(0, 4, 2, 1);
        close(0, 2, 2, 1);
        close(10, 2, 2, 1);
        close(130, 2, 4, 1);
        wait_win("tmo_win");
        push(3, 4); push(1, 14); window(4);
        wait_pulse(1, "tmo_resume");
        ratio_valid = 1;
        ratio = 0;
        @(posedge clk); #1;
        ratio_valid = 0;
        close(30, 4, 4, 1);
        wait_pulse(1, "en_p1_rise");
        wait_pulse(0, "en_p1_fall");
        wait_pulse(1, "en_p2_rise");
        en = 0;
        chk("en_queue", q.size(), 3);
        q.delete();
        push(1, 4); push(0, 1);
        @(posedge clk); #1;
        chk("en_drop_pulse", pulse_out, 0);
        chk("en_drop_toff", toff_cur, 4);
        repeat (3) @(posedge clk);
        #1;
        en = 1;
        window(4);
        @(posedge clk); #1;
        chk("reen_idle", pulse_out, 0);
        @(posedge clk); #1;
        chk("reen_on", pulse_out, 1);
        close(50, 4, 6, 1);
        wait_pulse(1, "rst_p1_rise");
        wait_pulse(0, "rst_p1_fall");
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("arst_pulse", pulse_out, 0);
        chk("arst_win", win_done, 0);
        chk("arst_tmo", timeout, 0);
        chk("arst_alarm", alarm, 0);
        chk("arst_toff", toff_cur, 5);
        chk("arst_queue", q.size(), 3);
        q.delete();
        en = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        en = 1;
        window(5);
        close(0, 5, 3, 1);
`ifdef GAP_SHORT_ALARM_EN
        close(90, 3, 5, 1);
        close(90, 5, 7, 1);
        close(90, 7, 8, 1);
        repeat (3) close(90, 8, 8, 1);
        close(90, 8, 8, 0);
        @(posedge clk); #1;
        chk("alarm_set", alarm, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("alarm_idle_pulse", pulse_out, 0);
        chk("alarm_hold", alarm, 1);
        en = 0;
        @(posedge clk); #1;
        chk("alarm_clear", alarm, 0);
`else
        wait_win("last_win");
        en = 0;
        repeat (15) @(posedge clk);
        #1;
        chk("alarm_off", alarm, 0);
`endif
        chk("queue_left", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
